host_reg_responder: RTL and testbench

HOST_REG_RESPONDER -- requirements
Module: host_reg_responder

---
 rtl/host_reg_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/host_reg_responder.sv | 132 +++++++++++++
 tb/tb_host_reg_responder.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_reg_pkg.sv
// Shared types and constants for the host register responder.
// Pin positions on the uio bus, register-file geometry and the handshake FSM states.
package host_reg_pkg;

    localparam int ADDR_W      = 3;
    localparam int DATA_W      = 8;
    localparam int NUM_REGS    = 1 << ADDR_W;

    // Bit positions on uio_in / uio_out
    localparam int REQ_BIT     = 0;
    localparam int WE_BIT      = 1;
    localparam int ADDR_LSB    = 2;
    localparam int ACK_BIT     = 7;

    // Register that turns into the transfer counter when XFER_COUNT_EN is defined
    localparam int STATUS_ADDR = 7;

    // Only the ack pin is ever driven on the bidirectional bus
    localparam logic [7:0] UIO_OE_VAL = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Host command fields, sampled directly from the pins while in EXEC
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } host_cmd_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous control bit.
// Both stages clear on reset, so a request held across reset release still
// goes through the full two-cycle latency.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so each flop samples the pre-edge value regardless of statement order.
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/host_reg_responder.sv
// Host register responder: 8 x 8-bit register file behind a four-phase
// req/ack handshake (IDLE -> EXEC -> ACK -> IDLE).
// Only req is synchronized; we, addr and write data are taken straight from
// the pins in EXEC, when the host is holding them stable.
// Optional build macro XFER_COUNT_EN: register 7 becomes a read-only count of
// executed transactions (wraps 255 -> 0); writes to it are acknowledged and dropped.
module host_reg_responder
    import host_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef XFER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(STATUS_ADDR);

    state_t            state_q;
    state_t            state_d;
    logic              req_sync;
    logic              ack_q;
    logic              ack_d;
    logic              exec;
    logic              status_hit;
    host_cmd_t         cmd;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] status_next;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              unused_uio_bits;

    sync_2ff u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (uio_in[REQ_BIT]),
        .q   (req_sync)
    );

    assign cmd = '{
        we:   uio_in[WE_BIT],
        addr: uio_in[ADDR_LSB +: ADDR_W],
        data: ui_in
    };

    assign exec        = (state_q == ST_EXEC);
    assign status_hit  = COUNT_EN && (cmd.addr == STATUS_IDX);
    // Counter value including the transaction now executing
    assign status_next = regs_q[STATUS_IDX] + DATA_W'(1);

    // Upper uio bits are not part of the command
    assign unused_uio_bits = &{1'b0, uio_in[7:ADDR_LSB+ADDR_W]};

    // Next state and next ack; ack only rises out of ACK and stays while req is held.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
        state_d = state_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // ena is only consulted here; a transaction already under way always completes
                if (req_sync && ena) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // Keep ack while the host holds req; if req was already gone,
                // still give the host a single ack pulse on the first ACK cycle.
                ack_d = req_sync || !ack_q;
                if (!req_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Register file: commit host writes in EXEC and advance the transfer counter when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file must clear on reset, so it is built from flops; a RAM macro has no reset port.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (exec) begin
            if (cmd.we && !status_hit) begin
                regs_q[cmd.addr] <= cmd.data;
            end
            if (COUNT_EN) begin
                regs_q[STATUS_IDX] <= status_next;
            end
        end
    end

    // Read data register: loaded by reads in EXEC, untouched by writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (exec && !cmd.we) begin
            rd_data_q <= status_hit ? status_next : regs_q[cmd.addr];
        end
    end

    assign uo_out  = rd_data_q;
    assign uio_out = {ack_q, 7'b0};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_host_reg_responder.sv
// Self-checking bench for host_reg_responder.
// A plain array model of the register file (plus the transfer counter when
// XFER_COUNT_EN is defined) supplies every expected value; handshake timing is
// checked against fixed cycle counts from the sampling edge of req.
module tb_host_reg_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_regs [8];
    logic [7:0] model_uo;

    host_reg_responder dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model ----------------------------------------------------

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_uo = 8'h00;
    endtask

    task automatic model_commit(input bit we, input logic [2:0] addr, input logic [7:0] data);
`ifdef XFER_COUNT_EN
        model_regs[7] = model_regs[7] + 8'd1;
        if (we && addr != 3'd7) model_regs[addr] = data;
`else
        if (we) model_regs[addr] = data;
`endif
        if (!we) model_uo = model_regs[addr];
    endtask

    // Stimulus helpers ----------------------------------------------------

    task automatic drive_req(input bit req, input bit we, input logic [2:0] addr, input logic [7:0] data);
        ui_in  = data;
        uio_in = {3'($urandom), addr, we, req};
    endtask

    // Full four-phase transaction starting at a negedge.
    // lat: index of the first edge after req is sampled at which ack is seen high (-1 if never).
    // rel: same for ack low after req is dropped.
    task automatic run_txn(input bit we, input logic [2:0] addr, input logic [7:0] data,
                           output int lat, output int rel);
        lat = -1;
        rel = -1;
        drive_req(1'b1, we, addr, data);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b1) begin
                lat = k;
                break;
            end
        end
        uio_in[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b0) begin
                rel = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Tests -----------------------------------------------------------------

    task automatic test_reset();
        int lat;
        int rel;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (uio_oe !== 8'h80) begin
            failures++;
            $display("FAIL reset_oe_during: got %0h expected 80", uio_oe);
        end
        rst = 1'b0;
        model_reset();

        // Dirty a few registers and the read register, then reset mid-cycle
        run_txn(1'b1, 3'd0, 8'hC3, lat, rel); model_commit(1'b1, 3'd0, 8'hC3);
        run_txn(1'b1, 3'd6, 8'h3E, lat, rel); model_commit(1'b1, 3'd6, 8'h3E);
        run_txn(1'b0, 3'd0, 8'h00, lat, rel); model_commit(1'b0, 3'd0, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL reset_pre_read: got %0h expected %0h", uo_out, model_uo);
        end

        #2 rst = 1'b1;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_uo_out: got %0h expected 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_uio_out: got %0h expected 00", uio_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (uio_oe !== 8'h80) begin
            failures++;
            $display("FAIL reset_oe_after: got %0h expected 80", uio_oe);
        end

        for (int a = 0; a < 8; a++) begin
            run_txn(1'b0, 3'(a), 8'($urandom), lat, rel);
            model_commit(1'b0, 3'(a), 8'h00);
            checks++;
            if (uo_out !== model_uo) begin
                failures++;
                $display("FAIL reset_read_addr%0d: got %0h expected %0h", a, uo_out, model_uo);
            end
        end
    endtask

    task automatic test_ena_gating();
        int lat;
        int rel;
        // Request with the block disabled: never acknowledged, nothing written
        ena = 1'b0;
        run_txn(1'b1, 3'd1, 8'h5A, lat, rel);
        checks++;
        if (lat !== -1) begin
            failures++;
            $display("FAIL ena_off_ack: got ack at %0d expected none (-1)", lat);
        end
        ena = 1'b1;
        run_txn(1'b0, 3'd1, 8'h00, lat, rel);
        model_commit(1'b0, 3'd1, 8'h00);
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL ena_off_reg1: got %0h expected 00", uo_out);
        end

        // ena falls while in EXEC: the transaction still completes
        lat = -1;
        drive_req(1'b1, 1'b1, 3'd4, 8'h6D);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 2) ena = 1'b0;
            if (uio_out[7] === 1'b1) begin
                lat = k;
                break;
            end
        end
        model_commit(1'b1, 3'd4, 8'h6D);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL ena_drop_exec_ack: got latency %0d expected 4", lat);
        end
        run_txn(1'b0, 3'd4, 8'h00, lat, rel);
        model_commit(1'b0, 3'd4, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL ena_drop_exec_data: got %0h expected %0h", uo_out, model_uo);
        end
    endtask

    task automatic test_write_read();
        int lat;
        int rel;
        logic [7:0] uo_before;
        uo_before = uo_out;
        run_txn(1'b1, 3'd3, 8'hA5, lat, rel);
        model_commit(1'b1, 3'd3, 8'hA5);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL wr_ack_latency: got %0d expected 4", lat);
        end
        checks++;
        if (uo_out !== uo_before) begin
            failures++;
            $display("FAIL wr_uo_unchanged: got %0h expected %0h", uo_out, uo_before);
        end
        run_txn(1'b0, 3'd3, 8'h00, lat, rel);
        model_commit(1'b0, 3'd3, 8'h00);
        checks++;
        if (uo_out !== 8'hA5) begin
            failures++;
            $display("FAIL rd_addr3: got %0h expected a5", uo_out);
        end

        for (int n = 0; n < 24; n++) begin
            automatic bit         we = 1'($urandom);
            automatic logic [2:0] a  = 3'($urandom);
            automatic logic [7:0] d  = 8'($urandom);
            run_txn(we, a, d, lat, rel);
            model_commit(we, a, d);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL rand%0d_latency: got %0d expected 4", n, lat);
            end
            checks++;
            if (rel !== 2) begin
                failures++;
                $display("FAIL rand%0d_release: got %0d expected 2", n, rel);
            end
            checks++;
            if (uo_out !== model_uo) begin
                failures++;
                $display("FAIL rand%0d_uo_out: got %0h expected %0h (we=%0d addr=%0d)", n, uo_out, model_uo, we, a);
            end
        end
    endtask

    task automatic test_handshake();
        int lat;
        int rel;
        int highs;
        lat = -1;
        rel = -1;
        drive_req(1'b1, 1'b1, 3'd5, 8'h3C);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b1) begin
                lat = k;
                break;
            end
        end
        model_commit(1'b1, 3'd5, 8'h3C);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL hold_ack_latency: got %0d expected 4", lat);
        end

        // Keep req high with changing data: ack must stay and nothing recommits
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            ui_in = 8'h3C ^ 8'($urandom_range(1, 255));
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b1) highs++;
        end
        checks++;
        if (highs !== 10) begin
            failures++;
            $display("FAIL hold_ack_steady: got %0d high cycles expected 10", highs);
        end

        uio_in[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b0) begin
                rel = k;
                break;
            end
        end
        checks++;
        if (rel !== 2) begin
            failures++;
            $display("FAIL hold_ack_release: got %0d expected 2", rel);
        end

        highs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (uio_out[7] !== 1'b0) highs++;
        end
        checks++;
        if (highs !== 0) begin
            failures++;
            $display("FAIL hold_no_retrigger: got %0d ack cycles expected 0", highs);
        end

        run_txn(1'b0, 3'd5, 8'h00, lat, rel);
        model_commit(1'b0, 3'd5, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL hold_single_commit: got %0h expected %0h", uo_out, model_uo);
        end
    endtask

    task automatic test_req_drop_in_exec();
        int lat;
        int rel;
        int highs;
        drive_req(1'b1, 1'b1, 3'd6, 8'h99);
        repeat (3) @(posedge clk);
        @(negedge clk);
        uio_in[0] = 1'b0;
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b1) highs++;
        end
        model_commit(1'b1, 3'd6, 8'h99);
        checks++;
        if (highs !== 1) begin
            failures++;
            $display("FAIL drop_exec_ack_pulse: got %0d ack cycles expected 1", highs);
        end
        run_txn(1'b0, 3'd6, 8'h00, lat, rel);
        model_commit(1'b0, 3'd6, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL drop_exec_commit: got %0h expected %0h", uo_out, model_uo);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL drop_exec_next_txn: got latency %0d expected 4", lat);
        end
    endtask

    task automatic test_reset_mid_txn();
        int lat;
        int rel;
        // Reset lands the cycle before EXEC: the write is discarded
        drive_req(1'b1, 1'b1, 3'd2, 8'h77);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (uio_out[7] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ack: got %0b expected 0", uio_out[7]);
        end
        @(negedge clk);
        uio_in[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_txn(1'b0, 3'd2, 8'h00, lat, rel);
        model_commit(1'b0, 3'd2, 8'h00);
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_reg2: got %0h expected 00", uo_out);
        end

        // req held high through reset release starts a normal transaction
        rst = 1'b1;
        drive_req(1'b1, 1'b1, 3'd0, 8'h42);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (uio_out[7] === 1'b1) begin
                lat = k;
                break;
            end
        end
        model_commit(1'b1, 3'd0, 8'h42);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL rst_release_held_req: got latency %0d expected 4", lat);
        end
        run_txn(1'b0, 3'd0, 8'h00, lat, rel);
        model_commit(1'b0, 3'd0, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL rst_release_data: got %0h expected %0h", uo_out, model_uo);
        end
    endtask

    task automatic test_status_reg();
        int lat;
        int rel;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`ifdef XFER_COUNT_EN
        for (int n = 0; n < 5; n++) begin
            automatic bit         we = 1'($urandom);
            automatic logic [2:0] a  = 3'($urandom_range(0, 6));
            automatic logic [7:0] d  = 8'($urandom);
            run_txn(we, a, d, lat, rel);
            model_commit(we, a, d);
        end
        run_txn(1'b0, 3'd7, 8'h00, lat, rel);
        model_commit(1'b0, 3'd7, 8'h00);
        checks++;
        if (uo_out !== 8'h06) begin
            failures++;
            $display("FAIL cnt_after_5: got %0h expected 06", uo_out);
        end
        run_txn(1'b1, 3'd7, 8'hFF, lat, rel);
        model_commit(1'b1, 3'd7, 8'hFF);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL cnt_write_ack: got latency %0d expected 4", lat);
        end
        run_txn(1'b0, 3'd7, 8'h00, lat, rel);
        model_commit(1'b0, 3'd7, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL cnt_write_ignored: got %0h expected %0h", uo_out, model_uo);
        end
        for (int n = 0; n < 256; n++) begin
            automatic bit         we = 1'($urandom);
            automatic logic [2:0] a  = 3'($urandom);
            automatic logic [7:0] d  = 8'($urandom);
            run_txn(we, a, d, lat, rel);
            model_commit(we, a, d);
        end
        run_txn(1'b0, 3'd7, 8'h00, lat, rel);
        model_commit(1'b0, 3'd7, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL cnt_wrap: got %0h expected %0h", uo_out, model_uo);
        end
`else
        run_txn(1'b1, 3'd7, 8'hFF, lat, rel);
        model_commit(1'b1, 3'd7, 8'hFF);
        run_txn(1'b0, 3'd7, 8'h00, lat, rel);
        model_commit(1'b0, 3'd7, 8'h00);
        checks++;
        if (uo_out !== 8'hFF) begin
            failures++;
            $display("FAIL reg7_rw_ff: got %0h expected ff", uo_out);
        end
        run_txn(1'b1, 3'd7, 8'h12, lat, rel);
        model_commit(1'b1, 3'd7, 8'h12);
        run_txn(1'b0, 3'd7, 8'h00, lat, rel);
        model_commit(1'b0, 3'd7, 8'h00);
        checks++;
        if (uo_out !== model_uo) begin
            failures++;
            $display("FAIL reg7_rw_12: got %0h expected %0h", uo_out, model_uo);
        end
`endif
    endtask

    // Sequence ---------------------------------------------------------------

    initial begin
        test_reset();
        test_ena_gating();
        test_write_read();
        test_handshake();
        test_req_drop_in_exec();
        test_reset_mid_txn();
        test_status_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
